// File: rtl/axi_lite_master_pkg.sv
// -----------------------------------------------------------------------------
// axi_lite_master_pkg
// Shared definitions for the AXI4-Lite single-outstanding initiator:
//   - state_e          : initiator FSM states
//   - AXI_RESP_*       : AXI response codes, plus RESP_LOCAL_TIMEOUT which the
//                        initiator reports when its own watchdog expires
//   - SPI_REG_*        : byte offsets of the SPI controller register map that
//                        this initiator normally targets
//   - chan_done()      : "this valid/ready channel is finished by the end of
//                        the current cycle" helper
// No ports (package).
// -----------------------------------------------------------------------------
package axi_lite_master_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WRITE     = 3'd1,
      ST_READ_ADDR = 3'd2,
      ST_READ_DATA = 3'd3,
      ST_RESP      = 3'd4
   } state_e;

   localparam logic [1:0] AXI_RESP_OKAY      = 2'b00;
   localparam logic [1:0] AXI_RESP_EXOKAY    = 2'b01;
   localparam logic [1:0] AXI_RESP_SLVERR    = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR    = 2'b11;
   localparam logic [1:0] RESP_LOCAL_TIMEOUT = 2'b11;

   localparam logic [31:0] SPI_REG_CTRL   = 32'h0000_0000;
   localparam logic [31:0] SPI_REG_STATUS = 32'h0000_0004;
   localparam logic [31:0] SPI_REG_DATA   = 32'h0000_0008;

   // A channel is done when its valid has already dropped (handshake in an
   // earlier cycle) or when it is handshaking right now.
   function automatic logic chan_done(input logic valid, input logic ready);
      return ~valid | ready;
   endfunction

endpackage

// File: rtl/axi_lite_master_wdog.sv
// -----------------------------------------------------------------------------
// axi_lite_master_wdog
// Response-phase watchdog for axi_lite_master. Only instantiated when the
// top is built with AXI_LITE_MASTER_TIMEOUT_EN defined.
//
// The counter holds the number of clock edges since the last cycle in which
// active_i was low, so fire_o asserts in the cycle whose closing edge is the
// LIMIT-th edge after the response phase was entered. Registering fire_o in
// the top therefore makes the timeout visible exactly LIMIT cycles after the
// handshake that opened the phase. Leaving the phase reloads the counter,
// which gives a fresh count on every entry.
//
// Ports:
//   clk_i     in   clock, rising edge
//   rst_i     in   synchronous active-high reset
//   active_i  in   high while the owner is waiting for a B or R response
//   fire_o    out  limit reached this cycle (combinational)
// -----------------------------------------------------------------------------
module axi_lite_master_wdog #(
   parameter int unsigned LIMIT = 256
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic active_i,
   output logic fire_o
);

   localparam int unsigned CW = $clog2(LIMIT + 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign cnt_d  = active_i ? (cnt_q + CW'(1)) : CW'(1);
   assign fire_o = active_i & (cnt_q == CW'(LIMIT - 1));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= CW'(1);
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/axi_lite_master.sv
// -----------------------------------------------------------------------------
// axi_lite_master
// AXI4-Lite initiator with one transaction outstanding. A command
// (valid/ready) is turned into an AXI-Lite write (AW+W+B) or read (AR+R),
// and the result is returned on a response (valid/ready) handshake.
//
// Optional feature: define AXI_LITE_MASTER_TIMEOUT_EN to add a response-phase
// watchdog (axi_lite_master_wdog). When it expires the response is completed
// locally with o_rsp_resp = 2'b11 and o_rsp_rdata = 0, and o_timeout pulses.
// Without the macro the block waits indefinitely and o_timeout is tied low.
//
// Ports:
//   FCLK_CLK0              in   clock, rising edge
//   RST                    in   synchronous active-high reset
//   i_cmd_valid/o_cmd_ready     command handshake
//   i_cmd_write            in   1 = write, 0 = read
//   i_cmd_addr/wdata/wstrb in   command payload
//   o_rsp_valid/i_rsp_ready     response handshake
//   o_rsp_write            out  write flag of the completed command
//   o_rsp_rdata            out  read data (0 for writes)
//   o_rsp_resp             out  AXI response, or 2'b11 on local timeout
//   o_timeout              out  one-cycle watchdog pulse
//   AXI_*                       AXI4-Lite initiator channels AW, W, B, AR, R
// -----------------------------------------------------------------------------
module axi_lite_master
   import axi_lite_master_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic        FCLK_CLK0,
   input  logic        RST,

   input  logic        i_cmd_valid,
   output logic        o_cmd_ready,
   input  logic        i_cmd_write,
   input  logic [31:0] i_cmd_addr,
   input  logic [31:0] i_cmd_wdata,
   input  logic [3:0]  i_cmd_wstrb,

   output logic        o_rsp_valid,
   input  logic        i_rsp_ready,
   output logic        o_rsp_write,
   output logic [31:0] o_rsp_rdata,
   output logic [1:0]  o_rsp_resp,
   output logic        o_timeout,

   output logic [31:0] AXI_awaddr,
   output logic [2:0]  AXI_awprot,
   output logic        AXI_awvalid,
   input  logic        AXI_awready,

   output logic [31:0] AXI_wdata,
   output logic [3:0]  AXI_wstrb,
   output logic        AXI_wvalid,
   input  logic        AXI_wready,

   input  logic [1:0]  AXI_bresp,
   input  logic        AXI_bvalid,
   output logic        AXI_bready,

   output logic [31:0] AXI_araddr,
   output logic [2:0]  AXI_arprot,
   output logic        AXI_arvalid,
   input  logic        AXI_arready,

   input  logic [31:0] AXI_rdata,
   input  logic [1:0]  AXI_rresp,
   input  logic        AXI_rvalid,
   output logic        AXI_rready
);

   state_e      state_q;
   state_e      state_d;

   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [3:0]  wstrb_q;
   logic        write_q;

   logic        awvalid_q;
   logic        wvalid_q;
   logic        arvalid_q;

   logic [31:0] rdata_q;
   logic [1:0]  resp_q;

   logic        cmd_fire;
   logic        aw_ok;
   logic        w_ok;
   logic        b_done;
   logic        ar_done;
   logic        r_done;
   logic        wd_fire;

   assign cmd_fire = i_cmd_valid & o_cmd_ready;

   // A B beat only finishes the write once both AW and W are finished in this
   // cycle or earlier; this covers the slave that raises bvalid in the same
   // cycle as the AW/W handshakes. An early B is simply not taken.
   assign aw_ok   = chan_done(awvalid_q, AXI_awready);
   assign w_ok    = chan_done(wvalid_q, AXI_wready);
   assign b_done  = (state_q == ST_WRITE) & AXI_bvalid & aw_ok & w_ok;
   assign ar_done = (state_q == ST_READ_ADDR) & arvalid_q & AXI_arready;
   assign r_done  = (state_q == ST_READ_DATA) & AXI_rvalid;

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
   logic wd_active;
   logic wd_expired;
   logic timeout_q;

   // Watch only the response phase: a write once AW and W are both done,
   // or a read waiting for R. Address-phase stalls are never timed out.
   assign wd_active = ((state_q == ST_WRITE) & ~awvalid_q & ~wvalid_q) |
                      (state_q == ST_READ_DATA);

   axi_lite_master_wdog #(
      .LIMIT    (TIMEOUT_CYCLES)
   ) u_wdog (
      .clk_i    (FCLK_CLK0),
      .rst_i    (RST),
      .active_i (wd_active),
      .fire_o   (wd_expired)
   );

   // A genuine response arriving in the expiry cycle takes precedence.
   assign wd_fire = wd_expired & ~b_done & ~r_done;

   always_ff @(posedge FCLK_CLK0) begin
      if (RST) begin
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= wd_fire;
      end
   end

   assign o_timeout = timeout_q;
`else
   assign wd_fire   = 1'b0;
   assign o_timeout = 1'b0;
`endif

   // ---------------------------------------------------------------- state
   always_ff @(posedge FCLK_CLK0) begin
      if (RST) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (cmd_fire) begin
               state_d = i_cmd_write ? ST_WRITE : ST_READ_ADDR;
            end
         end
         ST_WRITE: begin
            if (b_done || wd_fire) begin
               state_d = ST_RESP;
            end
         end
         ST_READ_ADDR: begin
            // R is not looked at in the AR cycle; READ_DATA starts next cycle.
            if (ar_done) begin
               state_d = ST_READ_DATA;
            end
         end
         ST_READ_DATA: begin
            if (r_done || wd_fire) begin
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            if (i_rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      o_cmd_ready = 1'b0;
      o_rsp_valid = 1'b0;
      AXI_bready  = 1'b0;
      AXI_rready  = 1'b0;
      unique case (state_q)
         // Ready is held low while reset is asserted so nothing is accepted
         // into a block that is being cleared.
         ST_IDLE:      o_cmd_ready = ~RST;
         ST_WRITE:     AXI_bready  = 1'b1;
         ST_READ_ADDR: ;
         ST_READ_DATA: AXI_rready  = 1'b1;
         ST_RESP:      o_rsp_valid = 1'b1;
         default:      ;
      endcase
   end

   // ------------------------------------------------------- AXI valid flags
   // Raised together on command acceptance (visible the next cycle) and each
   // dropped independently by its own handshake.
   always_ff @(posedge FCLK_CLK0) begin
      if (RST) begin
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         arvalid_q <= 1'b0;
      end else begin
         awvalid_q <= (cmd_fire &  i_cmd_write) | (awvalid_q & ~AXI_awready);
         wvalid_q  <= (cmd_fire &  i_cmd_write) | (wvalid_q  & ~AXI_wready);
         arvalid_q <= (cmd_fire & ~i_cmd_write) | (arvalid_q & ~AXI_arready);
      end
   end

   // -------------------------------------------------------- command capture
   always_ff @(posedge FCLK_CLK0) begin
      if (cmd_fire) begin
         addr_q  <= i_cmd_addr;
         wdata_q <= i_cmd_wdata;
         wstrb_q <= i_cmd_wstrb;
      end
   end

   always_ff @(posedge FCLK_CLK0) begin
      if (RST) begin
         write_q <= 1'b0;
      end else if (cmd_fire) begin
         write_q <= i_cmd_write;
      end
   end

   // ------------------------------------------------------- response capture
   always_ff @(posedge FCLK_CLK0) begin
      if (RST) begin
         rdata_q <= '0;
         resp_q  <= AXI_RESP_OKAY;
      end else if (b_done) begin
         rdata_q <= '0;
         resp_q  <= AXI_bresp;
      end else if (r_done) begin
         rdata_q <= AXI_rdata;
         resp_q  <= AXI_rresp;
      end else if (wd_fire) begin
         rdata_q <= '0;
         resp_q  <= RESP_LOCAL_TIMEOUT;
      end
   end

   assign o_rsp_write = write_q;
   assign o_rsp_rdata = rdata_q;
   assign o_rsp_resp  = resp_q;

   assign AXI_awaddr  = addr_q;
   assign AXI_awprot  = 3'b000;
   assign AXI_awvalid = awvalid_q;
   assign AXI_wdata   = wdata_q;
   assign AXI_wstrb   = wstrb_q;
   assign AXI_wvalid  = wvalid_q;
   assign AXI_araddr  = addr_q;
   assign AXI_arprot  = 3'b000;
   assign AXI_arvalid = arvalid_q;

endmodule

// File: doc/axi_lite_master.md
# axi_lite_master

AXI4-Lite single-outstanding initiator that turns a simple command/response handshake into AXI-Lite read and write transactions. It drives the same 32-bit AXI-Lite register interface that the SPI controller's register slave terminates. Typical users are an on-chip sequencer or a loopback test harness, which talk to the SPI register map at offsets 0x00 (control), 0x04 (status) and 0x08 (data).

## Interface
- TIMEOUT_CYCLES, 256: response-phase watchdog limit; used only with the timeout feature.
- FCLK_CLK0  in  1  clock; all logic on its rising edge.
- RST  in  1  synchronous, active-high reset.
- i_cmd_valid  in  1  command offered.
- o_cmd_ready  out  1  command accepted when both valid and ready are high.
- i_cmd_write  in  1  1 = write, 0 = read.
- i_cmd_addr  in  32  byte address.
- i_cmd_wdata  in  32  write data.
- i_cmd_wstrb  in  4  write byte strobes.
- o_rsp_valid  out  1  response available.
- i_rsp_ready  in  1  response consumed.
- o_rsp_write  out  1  echoes i_cmd_write of the completed command.
- o_rsp_rdata  out  32  read data; 0 for writes.
- o_rsp_resp  out  2  AXI response code, or 2'b11 on local timeout.
- o_timeout  out  1  one-cycle pulse when the watchdog fires.
- AXI_awaddr, AXI_awprot(3'b000), AXI_awvalid  out; AXI_awready  in.
- AXI_wdata, AXI_wstrb, AXI_wvalid  out; AXI_wready  in.
- AXI_bresp, AXI_bvalid  in; AXI_bready  out.
- AXI_araddr, AXI_arprot(3'b000), AXI_arvalid  out; AXI_arready  in.
- AXI_rdata, AXI_rresp, AXI_rvalid  in; AXI_rready  out.

## Operation
- States: IDLE, WRITE, READ_ADDR, READ_DATA, RESP.
- o_cmd_ready is 1 only in IDLE.
- On command handshake, addr/wdata/wstrb/write are registered.
  - Write goes to WRITE; read goes to READ_ADDR.
- WRITE:
  - AXI_awvalid and AXI_wvalid both rise together.
  - Each drops independently after its own handshake; payload stays stable until that handshake.
  - AXI_bready is 1 for the whole state.
  - A B handshake completes the state only if AW and W have both handshaken in the same or an earlier cycle.
  - The slave asserts bvalid combinationally with awvalid&wvalid, so the same-cycle AW+W+B case is mandatory.
  - On completion, bresp is captured and the state moves to RESP.
- READ_ADDR:
  - AXI_arvalid is held until arready.
  - The state moves to READ_DATA on the cycle after the AR handshake; rvalid is not sampled in the AR cycle.
- READ_DATA:
  - AXI_rready is 1.
  - On rvalid, rdata and rresp are captured and the state moves to RESP.
- RESP:
  - o_rsp_valid is 1; response fields stay stable until i_rsp_ready, then the state returns to IDLE.
  - The next command is accepted the cycle after the response handshake; there is no same-cycle bypass.
- bready and rready are 0 outside WRITE and READ_DATA respectively.
- Reset, including mid-transaction:
  - State goes to IDLE; all valid/ready outputs, o_rsp_*, and o_timeout go to 0.
  - The captured command is dropped with no response; o_cmd_ready is 1 the cycle after reset deasserts.

## Timing
- Command accepted in cycle N; AW/W/AR valid is registered and visible from N+1.
- Against the zero-wait SPI register slave:
  - Write: AW/W/B all at N+1; o_rsp_valid at N+2.
  - Read: AR at N+1; rvalid at N+2; o_rsp_valid at N+3.
- Throughput is one outstanding transaction; minimum write period is 3 cycles when i_rsp_ready is held high.

## Configuration
- AXI_LITE_MASTER_TIMEOUT_EN defined:
  - A counter runs in the response phase only: WRITE after both AW and W are done, and READ_DATA.
  - When it reaches TIMEOUT_CYCLES, the block pulses o_timeout, sets o_rsp_resp=2'b11 and o_rsp_rdata=0, and moves to RESP.
  - Valids already handshaken are not affected; any later B/R from the slave is ignored.
  - The counter clears on entry to each response phase.
- Undefined: no counter, o_timeout tied to 0, and the block waits indefinitely.

## Structure
- axi_lite_master_pkg holds:
  - the state enum;
  - AXI_RESP_OKAY / EXOKAY / SLVERR / DECERR;
  - RESP_LOCAL_TIMEOUT (2'b11);
  - the SPI register offsets 0x00, 0x04, 0x08.
- Sub-module axi_lite_master_wdog (the counter plus compare) is instantiated only under the macro.

## Test plan
- Write 0x0000_0008 / 0xA5A5_1234 against the SPI register slave -> AW, W, and B all in N+1; o_rsp_valid at N+2 with resp 0; the data register reads back 0xA5A5_1234.
- Read 0x0000_0004 -> AR at N+1, R at N+2; o_rsp_rdata equals the status register value; resp 0.
- Stub slave gives awready 2 cycles before wready -> awvalid drops first, wdata stays stable, and B is accepted only after W completes.
- Hold i_rsp_ready=0 for 5 cycles -> o_rsp_* stable, o_cmd_ready=0, no new AXI activity.
- Assert RST during READ_DATA -> all outputs 0 next cycle; o_cmd_ready=1 after release; no o_rsp_valid.
- With macro and TIMEOUT_CYCLES=8, a stub slave that never sends rvalid -> o_timeout pulse and o_rsp_resp=2'b11 eight cycles after the AR handshake.
